// File: rtl/usb_tx_arbiter_if.sv
// Transmit-arbiter bus bundle: handshake request, two IN streams and the
// stream toward the ULPI transmit encoder, plus grant/busy status.
interface usb_tx_arbiter_if;
  logic       hsk_req_i;
  logic [3:0] hsk_pid_i;
  logic       hsk_ack_o;

  logic       s0_tvalid_i;
  logic       s0_tready_o;
  logic       s0_tlast_i;
  logic [7:0] s0_tdata_i;

  logic       s1_tvalid_i;
  logic       s1_tready_o;
  logic       s1_tlast_i;
  logic [7:0] s1_tdata_i;

  logic       m_tvalid_o;
  logic       m_tready_i;
  logic       m_tlast_o;
  logic [7:0] m_tdata_o;

  logic [1:0] grant_o;
  logic       busy_o;

  modport slave (
    input  hsk_req_i, hsk_pid_i,
    input  s0_tvalid_i, s0_tlast_i, s0_tdata_i,
    input  s1_tvalid_i, s1_tlast_i, s1_tdata_i,
    input  m_tready_i,
    output hsk_ack_o, s0_tready_o, s1_tready_o,
    output m_tvalid_o, m_tlast_o, m_tdata_o,
    output grant_o, busy_o
  );

  modport master (
    output hsk_req_i, hsk_pid_i,
    output s0_tvalid_i, s0_tlast_i, s0_tdata_i,
    output s1_tvalid_i, s1_tlast_i, s1_tdata_i,
    output m_tready_i,
    input  hsk_ack_o, s0_tready_o, s1_tready_o,
    input  m_tvalid_o, m_tlast_o, m_tdata_o,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Packet-atomic ULPI transmit arbiter: handshake has strict priority, EP0 and
// bulk IN alternate round-robin, with a programmable inter-packet gap.
module usb_tx_arbiter #(
  parameter int unsigned IPG_CYCLES = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  usb_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, HSK, EP0, EP1, GAP} state_e;

  localparam logic [3:0] IPG = IPG_CYCLES[3:0];

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_ep_q, last_ep_d;  // 1: bulk IN was served last

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_ep_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ep_q <= last_ep_d;
    end
  end

  // Packet end either enters the gap or, with a zero gap, goes straight to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_ep_d = last_ep_q;
    case (state_q)
      IDLE: begin
        if (bus.hsk_req_i)
          state_d = HSK;
        else if (bus.s0_tvalid_i && bus.s1_tvalid_i)
          state_d = last_ep_q ? EP0 : EP1;
        else if (bus.s0_tvalid_i)
          state_d = EP0;
        else if (bus.s1_tvalid_i)
          state_d = EP1;
      end
      HSK: begin
        if (bus.m_tready_i) begin
          state_d = (IPG != 4'd0) ? GAP : IDLE;
          cnt_d   = IPG;
        end
      end
      EP0: begin
        if (bus.s0_tvalid_i && bus.m_tready_i && bus.s0_tlast_i) begin
          last_ep_d = 1'b0;
          state_d   = (IPG != 4'd0) ? GAP : IDLE;
          cnt_d     = IPG;
        end
      end
      EP1: begin
        if (bus.s1_tvalid_i && bus.m_tready_i && bus.s1_tlast_i) begin
          last_ep_d = 1'b1;
          state_d   = (IPG != 4'd0) ? GAP : IDLE;
          cnt_d     = IPG;
        end
      end
      GAP: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency mux on the registered grant; data is forced to 0 when not valid.
  always_comb begin
    bus.hsk_ack_o   = 1'b0;
    bus.s0_tready_o = 1'b0;
    bus.s1_tready_o = 1'b0;
    bus.m_tvalid_o  = 1'b0;
    bus.m_tlast_o   = 1'b0;
    bus.m_tdata_o   = 8'h00;
    bus.grant_o     = 2'd0;
    bus.busy_o      = (state_q != IDLE);
    case (state_q)
      HSK: begin
        bus.grant_o    = 2'd1;
        bus.m_tvalid_o = 1'b1;
        bus.m_tlast_o  = 1'b1;
        bus.m_tdata_o  = {~bus.hsk_pid_i, bus.hsk_pid_i};
        bus.hsk_ack_o  = bus.m_tready_i;
      end
      EP0: begin
        bus.grant_o     = 2'd2;
        bus.s0_tready_o = bus.m_tready_i;
        bus.m_tvalid_o  = bus.s0_tvalid_i;
        bus.m_tlast_o   = bus.s0_tvalid_i & bus.s0_tlast_i;
        bus.m_tdata_o   = bus.s0_tvalid_i ? bus.s0_tdata_i : 8'h00;
      end
      EP1: begin
        bus.grant_o     = 2'd3;
        bus.s1_tready_o = bus.m_tready_i;
        bus.m_tvalid_o  = bus.s1_tvalid_i;
        bus.m_tlast_o   = bus.s1_tvalid_i & bus.s1_tlast_i;
        bus.m_tdata_o   = bus.s1_tvalid_i ? bus.s1_tdata_i : 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Packet-atomic transmit arbiter for the USB device core. It shares the single ULPI transmit byte stream between three requesters: the handshake generator (ACK/NAK/STALL), the EP0 control IN data path and the bulk IN data path. The handshake generator has strict priority, and EP0 and bulk IN alternate round-robin. The arbiter enforces a programmable inter-packet gap and sits between the endpoint logic and the ULPI transmit encoder, in the ULPI clock domain.

## Interface
Parameters:
- IPG_CYCLES, default 4: idle gap in cycles after each packet; legal range 0..15.

Ports (name, direction, width, meaning):
- aclk  in  1  ULPI-domain clock; all logic is on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- hsk_req_i  in  1  handshake request; held high until hsk_ack_o.
- hsk_pid_i  in  4  handshake PID nibble; stable while hsk_req_i is high.
- hsk_ack_o  out  1  one-cycle pulse when the handshake byte is accepted.
- s0_tvalid_i / s0_tready_o / s0_tlast_i  in/out/in  1  EP0 IN AXI stream.
- s0_tdata_i  in  8  EP0 IN data.
- s1_tvalid_i / s1_tready_o / s1_tlast_i  in/out/in  1  bulk IN AXI stream.
- s1_tdata_i  in  8  bulk IN data.
- m_tvalid_o / m_tready_i / m_tlast_o  out/in/out  1  stream to the ULPI transmit encoder.
- m_tdata_o  out  8  transmit byte.
- grant_o  out  2  current owner: 0 none, 1 handshake, 2 EP0, 3 bulk.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HSK, EP0, EP1, GAP. The state register and gap counter are registered. The datapath mux is combinational on the registered state.
- IDLE: grant_o=0, m_tvalid_o=0, all treadys 0. Next state is decided by these rules, in priority order:
  - hsk_req_i high -> HSK.
  - Only s0_tvalid_i high -> EP0; only s1_tvalid_i high -> EP1.
  - Both high -> the endpoint that was not served last, tracked by the last_ep register. Reset value of last_ep is "EP1", so EP0 wins the first tie.
- HSK:
  - m_tvalid_o=1, m_tlast_o=1, m_tdata_o={~hsk_pid_i, hsk_pid_i}.
  - On m_tready_i: hsk_ack_o=1 in the same cycle, then -> GAP.
- EP0/EP1:
  - m_tvalid_o, m_tlast_o and m_tdata_o follow the granted source.
  - The granted source's tready equals m_tready_i. The other source's tready is 0.
  - Source tvalid going low mid-packet gives m_tvalid_o=0 and the grant is held.
  - On tvalid&tready&tlast: last_ep is updated, then -> GAP.
- GAP:
  - The counter is loaded with IPG_CYCLES on entry, and the state is left after exactly IPG_CYCLES cycles, then -> IDLE.
  - If IPG_CYCLES=0, GAP is skipped and the packet end goes directly to IDLE.
- No preemption: a handshake request arriving during an EP packet waits until that packet and its gap complete.
- Handshakes do not update last_ep.
- Reset values: state IDLE, grant_o=0, busy_o=0, hsk_ack_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, s0_tready_o=0, s1_tready_o=0, last_ep=EP1, counter 0.
- Reset mid-packet: state goes to IDLE at the next edge and outputs take their reset values. Flushing the upstream partial packet is the sources' responsibility.

## Timing
- Request to output: a request sampled in IDLE at cycle N gives the grant state and the first m_tvalid_o at cycle N+1.
- Packet end to next grant: a last-beat transfer at cycle N gives GAP over N+1..N+IPG_CYCLES, IDLE at N+IPG_CYCLES+1 and the earliest next grant at N+IPG_CYCLES+2.
- With IPG_CYCLES=0, the earliest next grant is at N+2.
- The ready/data path through the arbiter has zero-cycle latency in the grant states. There is no buffering.
- m_tdata_o is 0 whenever m_tvalid_o=0.

## Test plan
- Reset, then idle: all outputs 0 and grant_o=0. Assert aresetn=0 mid-EP1 packet -> next cycle grant_o=0, m_tvalid_o=0.
- Handshake with hsk_pid_i=4'h2 (ACK) and m_tready_i=1:
  - m_tdata_o=8'hD2 and m_tlast_o=1 for 1 cycle.
  - hsk_ack_o pulses once.
  - busy_o stays high for 4 further gap cycles.
- Single EP0 packet of bytes 01..08 with m_tready_i=1:
  - 8 bytes are emitted in order with tlast on 08.
  - s1_tready_o stays 0 throughout.
- Both sources continuously valid with 3-byte packets:
  - Grants alternate 2,3,2,3.
  - Last beat to next first beat is exactly IPG_CYCLES+2 cycles.
- hsk_req_i asserted mid-EP1 packet:
  - EP1 completes unbroken, then the gap.
  - HSK is granted ahead of the pending EP0 request.
- Backpressure and bubbles: random m_tready_i and s1_tvalid_i bubbles -> byte stream identical to the source with the grant held throughout. Repeat with IPG_CYCLES=0 -> next grant 2 cycles after tlast.
